bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm.
- Sits directly upstream of the 6-digit seven-segment scan driver and supplies its 24-bit packed BCD_data input.
- Converts a 20-bit binary count from counters, ADC readouts or frequency meters into 6 BCD digits.
- Start/busy/done handshake, one-deep pending-request buffer, saturation at 999999.

---
 rtl/bkb_seg_pkg.sv | 34 +++
 rtl/bin2bcd_seq_dabble_step.sv | 32 +++
 rtl/bin2bcd_seq.sv | 142 ++++++++++++++
 tb/tb_bin2bcd_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/bkb_seg_pkg.sv
// Shared definitions for the seven-segment display path.
//   BCD_W   : width of one BCD digit
//   DIGITS  : number of BCD digits produced by the converter
//   BIN_W   : binary input width (also the number of shift iterations)
//   MAX_VAL : saturation value, 10^DIGITS - 1 (must fit in BIN_W bits)
//   state_e : converter FSM encoding (IDLE / SHIFT / COMMIT)
package bkb_seg_pkg;

  localparam int BCD_W   = 4;
  localparam int DIGITS  = 6;
  localparam int BIN_W   = 20;
  localparam int MAX_VAL = 999999;

  localparam int SCR_W = BCD_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W);

  localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VAL);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SHIFT  = ST_SHIFT,
    COMMIT = ST_COMMIT
  } state_e;

  // Clamp a binary value to the largest number the display can show.
  function automatic logic [BIN_W-1:0] sat_bin(input logic [BIN_W-1:0] v);
    return (v > MAX_BIN) ? MAX_BIN : v;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_dabble_step.sv
// One double-dabble iteration (purely combinational).
//   scr_in  : BCD scratch before this iteration
//   bin_in  : remaining binary bits, MSB shifts into the scratch next
//   scr_out : scratch after add-3 adjust and 1-bit left shift
//   bin_out : binary register after 1-bit left shift
module dabble_step
  import bkb_seg_pkg::*;
(
  input  logic [SCR_W-1:0] scr_in,
  input  logic [BIN_W-1:0] bin_in,
  output logic [SCR_W-1:0] scr_out,
  output logic [BIN_W-1:0] bin_out
);

  logic [SCR_W-1:0] adj;

  // Adjust every digit >= 5 before the shift so that doubling carries
  // correctly into the next decimal digit.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign adj[gi*BCD_W +: BCD_W] =
        (scr_in[gi*BCD_W +: BCD_W] >= 4'd5) ? scr_in[gi*BCD_W +: BCD_W] + 4'd3
                                            : scr_in[gi*BCD_W +: BCD_W];
    end
  endgenerate

  // The bit shifted out of the top digit is always 0 for saturated inputs.
  assign scr_out = SCR_W'({adj, bin_in[BIN_W-1]});
  assign bin_out = {bin_in[BIN_W-2:0], 1'b0};

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble) feeding the scan driver.
//   sys_clk   : system clock
//   sys_rst_n : asynchronous active-low reset
//   bin_data  : binary value, sampled on an edge with start=1
//   start     : single-cycle conversion request
//   busy      : conversion running or a request pending
//   done      : one-cycle pulse coincident with the BCD_data update
//   ovf       : committed value was saturated to MAX_VAL
//   BCD_data  : packed BCD result, digit 0 in [3:0]; held between commits
module bin2bcd_seq
  import bkb_seg_pkg::*;
(
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [BIN_W-1:0] bin_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [SCR_W-1:0] BCD_data
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [SCR_W-1:0] scr_q, scr_d;
  logic             ovf_int_q, ovf_int_d;
  logic             pend_q, pend_d;
  logic [BIN_W-1:0] pend_val_q, pend_val_d;
  logic [SCR_W-1:0] bcd_q, bcd_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [SCR_W-1:0] step_scr;
  logic [BIN_W-1:0] step_bin;
  logic             load_en;
  logic [BIN_W-1:0] load_val;

  dabble_step u_step (
    .scr_in  (scr_q),
    .bin_in  (bin_q),
    .scr_out (step_scr),
    .bin_out (step_bin)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    scr_d      = scr_q;
    ovf_int_d  = ovf_int_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    load_en    = 1'b0;
    load_val   = bin_data;

    case (state_q)
      IDLE: begin
        if (start) begin
          load_en = 1'b1;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        scr_d = step_scr;
        bin_d = step_bin;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d = COMMIT;
        end
        if (start) begin
          pend_val_d = bin_data;
          pend_d     = 1'b1;
        end
      end

      COMMIT: begin
        bcd_d  = scr_q;
        ovf_d  = ovf_int_q;
        done_d = 1'b1;
        // A start on this very edge is newer than any stored pending value,
        // so it wins and is launched directly without an IDLE cycle.
        if (start || pend_q) begin
          load_en    = 1'b1;
          load_val   = start ? bin_data : pend_val_q;
          pend_val_d = load_val;
          pend_d     = 1'b0;
          state_d    = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (load_en) begin
      bin_d     = sat_bin(load_val);
      ovf_int_d = (load_val > MAX_BIN);
      scr_d     = '0;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bin_q      <= '0;
      scr_q      <= '0;
      ovf_int_q  <= 1'b0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bin_q      <= bin_d;
      scr_q      <= scr_d;
      ovf_int_q  <= ovf_int_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != IDLE) | pend_q;
  assign done     = done_q;
  assign ovf      = ovf_q;
  assign BCD_data = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;
  import bkb_seg_pkg::*;

  logic             sys_clk   = 1'b0;
  logic             sys_rst_n = 1'b0;
  logic             start     = 1'b0;
  logic [BIN_W-1:0] bin_data  = '0;
  logic             busy, done, ovf;
  logic [SCR_W-1:0] BCD_data;

  int checks = 0;
  int errors = 0;

  bin2bcd_seq dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bin_data  (bin_data),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf),
    .BCD_data  (BCD_data)
  );

  always #10 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [BIN_W-1:0] bin;
    logic [SCR_W-1:0] bcd;
    logic             ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end else begin
      $display("ok   %s: %0h", name, got);
    end
  endtask

  // Launch one conversion from idle and check latency, result and busy.
  // Loop index n means edges k..k+n have occurred (k = start edge).
  task automatic run_one(input logic [BIN_W-1:0] v, input logic [SCR_W-1:0] exp_bcd,
                         input logic exp_ovf, input string tag);
    int lat;
    lat = -1;
    @(negedge sys_clk);
    start = 1'b1;
    bin_data = v;
    @(posedge sys_clk);
    #1 start = 1'b0;
    bin_data = '0;
    for (int n = 0; n <= 40; n++) begin
      @(negedge sys_clk);
      if (n == 0) chk({tag, " busy_after_start"}, 32'(busy), 32'd1);
      if (done) begin
        lat = n;
        chk({tag, " bcd"}, 32'(BCD_data), 32'(exp_bcd));
        chk({tag, " ovf"}, 32'(ovf), 32'(exp_ovf));
        chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
        break;
      end
    end
    chk({tag, " latency"}, 32'(lat), 32'd21);
    @(negedge sys_clk);
    chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int           ndone, d1, d2;
    logic [SCR_W-1:0] v1, v2;
    logic         o2;
    bit           busy_ok, seen_done;

    vecs[0] = '{20'd123456,  24'h123456, 1'b0};
    vecs[1] = '{20'd0,       24'h000000, 1'b0};
    vecs[2] = '{20'd999999,  24'h999999, 1'b0};
    vecs[3] = '{20'hFFFFF,   24'h999999, 1'b1};
    vecs[4] = '{20'd1000000, 24'h999999, 1'b1};
    vecs[5] = '{20'd7,       24'h000007, 1'b0};
    vecs[6] = '{20'd1000,    24'h001000, 1'b0};
    vecs[7] = '{20'd99999,   24'h099999, 1'b0};
    vecs[8] = '{20'd509,     24'h000509, 1'b0};
    vecs[9] = '{20'd850000,  24'h850000, 1'b0};

    // Reset state.
    repeat (3) @(negedge sys_clk);
    chk("reset bcd",  32'(BCD_data), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset ovf",  32'(ovf), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Table-driven single conversions with idle gaps.
    for (int i = 0; i < 10; i++) begin
      run_one(vecs[i].bin, vecs[i].bcd, vecs[i].ovf, $sformatf("vec%0d", i));
      repeat (2) @(negedge sys_clk);
    end

    // Pending requests: latest wins, immediate restart after commit.
    ndone = 0; d1 = -1; d2 = -1; v1 = '0; v2 = '0; o2 = 1'b1; busy_ok = 1'b1;
    @(negedge sys_clk);
    start = 1'b1;
    bin_data = 20'd111111;
    @(posedge sys_clk);
    #1 start = 1'b0;
    for (int n = 0; n <= 45; n++) begin
      @(negedge sys_clk);
      if (n < 42 && !busy) busy_ok = 1'b0;
      if (done) begin
        ndone++;
        if (ndone == 1) begin d1 = n; v1 = BCD_data; end
        else if (ndone == 2) begin d2 = n; v2 = BCD_data; o2 = ovf; end
      end
      if (n == 4) begin start = 1'b1; bin_data = 20'd222222; end
      else if (n == 9) begin start = 1'b1; bin_data = 20'd333333; end
      else start = 1'b0;
    end
    chk("pend done_count", 32'(ndone), 32'd2);
    chk("pend first_lat",  32'(d1), 32'd21);
    chk("pend first_bcd",  32'(v1), 32'h111111);
    chk("pend second_lat", 32'(d2), 32'd42);
    chk("pend second_bcd", 32'(v2), 32'h333333);
    chk("pend second_ovf", 32'(o2), 32'd0);
    chk("pend busy_held",  32'(busy_ok), 32'd1);
    chk("pend busy_end",   32'(busy), 32'd0);

    // Start on the COMMIT edge with nothing pending.
    ndone = 0; d1 = -1; d2 = -1; v1 = '0; v2 = '0; busy_ok = 1'b1;
    @(negedge sys_clk);
    start = 1'b1;
    bin_data = 20'd777;
    @(posedge sys_clk);
    #1 start = 1'b0;
    for (int n = 0; n <= 45; n++) begin
      @(negedge sys_clk);
      if (n < 42 && !busy) busy_ok = 1'b0;
      if (done) begin
        ndone++;
        if (ndone == 1) begin d1 = n; v1 = BCD_data; end
        else if (ndone == 2) begin d2 = n; v2 = BCD_data; end
      end
      if (n == 20) begin start = 1'b1; bin_data = 20'd500; end
      else start = 1'b0;
    end
    chk("commit done_count", 32'(ndone), 32'd2);
    chk("commit first_lat",  32'(d1), 32'd21);
    chk("commit first_bcd",  32'(v1), 32'h000777);
    chk("commit spacing",    32'(d2 - d1), 32'd21);
    chk("commit second_bcd", 32'(v2), 32'h000500);
    chk("commit no_idle",    32'(busy_ok), 32'd1);

    // Reset in the middle of a conversion.
    seen_done = 1'b0;
    @(negedge sys_clk);
    start = 1'b1;
    bin_data = 20'd654321;
    @(posedge sys_clk);
    #1 start = 1'b0;
    for (int n = 0; n <= 40; n++) begin
      @(negedge sys_clk);
      if (done) seen_done = 1'b1;
      if (n == 10) begin
        sys_rst_n = 1'b0;
        #1;
        chk("rst_mid bcd",  32'(BCD_data), 32'd0);
        chk("rst_mid busy", 32'(busy), 32'd0);
        chk("rst_mid ovf",  32'(ovf), 32'd0);
      end
      if (n == 12) sys_rst_n = 1'b1;
    end
    chk("rst_mid no_done", 32'(seen_done), 32'd0);
    chk("rst_mid bcd_held", 32'(BCD_data), 32'd0);
    run_one(20'd42, 24'h000042, 1'b0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
